// File: rtl/rom_fetch_ctrl_pkg.sv
// Shared fetch definitions: NOP encoding, controller states and the {pc, instr} queue entry.
package rom_fetch_ctrl_pkg;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam int          ENTRY_W  = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

endpackage

// File: rtl/rom_fetch_ctrl_queue.sv
// DEPTH-entry circular prefetch FIFO; one-cycle write-to-head latency, caller guards push/pop.
// Flush has priority and resets pointers and count together.
module rom_fetch_ctrl_queue
  import rom_fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/rom_fetch_ctrl.sv
// Fetch sequencer: PC, IDLE/RUN/DRAIN FSM and prefetch queue; ROM address to if_valid is 1 cycle.
// Holds pc when the queue is full and decode stalls. FETCH_MISALIGN_TRAP_EN adds the FAULT trap.
module rom_fetch_ctrl
  import rom_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter int          ROM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_instr,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        busy,
  output logic        end_of_rom,
  output logic        fetch_fault
);

  localparam int                CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  ONE_C    = CNT_W'(1);
  localparam logic [31:0]       ROM_LAST = 32'(ROM_BYTES - 4);

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic              eor_q;
  logic              push, pop, flush, q_empty_next;
  logic [CNT_W-1:0]  count;
  logic [ENTRY_W-1:0] q_dout;
  entry_t            head, din;
  logic [31:0]       redir_target;
  logic              misaligned;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q, fault_d;
  assign redir_target = redirect_pc;
  assign misaligned   = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign fetch_fault  = fault_q;
`else
  assign redir_target = redirect_pc & ~32'h3;
  assign misaligned   = 1'b0;
  assign fetch_fault  = 1'b0;
`endif

  assign din.pc    = pc_q;
  assign din.instr = rom_instr;
  assign head      = q_dout;

  rom_fetch_ctrl_queue #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (din),
    .dout  (q_dout),
    .count (count)
  );

  assign if_valid   = (count != '0);
  assign if_pc      = if_valid ? head.pc    : 32'h0;
  assign if_instr   = if_valid ? head.instr : NOP_INSN;
  assign rom_addr   = pc_q;
  assign busy       = (state_q != ST_IDLE) || if_valid;
  assign end_of_rom = eor_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    flush        = 1'b0;
    pop          = if_valid && if_ready && !redirect_valid;
    push         = (state_q == ST_RUN) && fetch_en && !redirect_valid &&
                   ((count < DEPTH_C) || pop);
    q_empty_next = (count == '0) || ((count == ONE_C) && pop && !push);
`ifdef FETCH_MISALIGN_TRAP_EN
    fault_d      = fault_q;
`endif

    case (state_q)
      ST_IDLE:  if (fetch_en) state_d = ST_RUN;
      ST_RUN:   if (!fetch_en) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (fetch_en)          state_d = ST_RUN;
        else if (q_empty_next) state_d = ST_IDLE;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      ST_FAULT: state_d = ST_FAULT;
`endif
      default:  state_d = ST_IDLE;
    endcase

    // Redirect wins over push/pop; IDLE and DRAIN only take the new pc.
    if (redirect_valid) begin
      flush = 1'b1;
      pc_d  = redir_target;
      if (state_q == ST_IDLE || state_q == ST_DRAIN) state_d = state_q;
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    if (misaligned) begin
      pc_d    = pc_q;
      state_d = ST_FAULT;
      fault_d = 1'b1;
    end else if (redirect_valid && state_q == ST_FAULT) begin
      state_d = fetch_en ? ST_RUN : ST_IDLE;
      fault_d = 1'b0;
    end
`endif

    if (push) pc_d = pc_q + 32'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      eor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (push && (pc_q > ROM_LAST)) eor_q <= 1'b1;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end
`endif

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Directed bench for rom_fetch_ctrl with a small behavioural ROM; hand-computed expectations.
module tb_rom_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] rom_addr;
  logic [31:0] rom_instr;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        busy;
  logic        end_of_rom;
  logic        fetch_fault;

  logic [31:0] rom [32];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Word i holds 0x13 | (i << 8), except the two words with fixed program content.
  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'h0000_0013 | (32'(i) << 8);
    rom[0]  = 32'hff60_0293;
    rom[18] = 32'h01d3_1863;
  end

  assign rom_instr = (rom_addr < 32'd128) ? rom[rom_addr[6:2]] : NOP;

  rom_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_addr       (rom_addr),
    .rom_instr      (rom_instr),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .busy           (busy),
    .end_of_rom     (end_of_rom),
    .fetch_fault    (fetch_fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; if_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    #12;
    check("rst_if_valid", 32'(if_valid), 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, NOP);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rom_addr", rom_addr, 32'h0);
    check("rst_eor", 32'(end_of_rom), 32'h0);
    check("rst_fault", 32'(fetch_fault), 32'h0);

    // Basic streaming from reset.
    #4; rst_n = 1'b1; fetch_en = 1'b1; if_ready = 1'b1;
    step();
    check("t1_idle_to_run_valid", 32'(if_valid), 32'h0);
    check("t1_busy", 32'(busy), 32'h1);
    step();
    check("t1_valid", 32'(if_valid), 32'h1);
    check("t1_pc0", if_pc, 32'h00);
    check("t1_instr0", if_instr, 32'hff60_0293);
    step();
    check("t1_pc4", if_pc, 32'h04);
    check("t1_instr4", if_instr, 32'h0000_0113);
    step();
    check("t1_pc8", if_pc, 32'h08);
    check("t1_instr8", if_instr, 32'h0000_0213);

    // Backpressure with a full queue.
    rst_n = 1'b0; if_ready = 1'b0;
    step();
    rst_n = 1'b1;
    step(5);
    check("t2_hold_addr", rom_addr, 32'h08);
    check("t2_head_pc", if_pc, 32'h00);
    check("t2_valid", 32'(if_valid), 32'h1);
    if_ready = 1'b1;
    step();
    check("t2_pop_pc4", if_pc, 32'h04);
    step();
    check("t2_pop_pc8", if_pc, 32'h08);
    check("t2_pop_instr8", if_instr, 32'h0000_0213);

    // Redirect while full.
    if_ready = 1'b0;
    do_redirect(32'h48);
    check("t3_flush_valid", 32'(if_valid), 32'h0);
    check("t3_addr", rom_addr, 32'h48);
    if_ready = 1'b1;
    step();
    check("t3_pc48", if_pc, 32'h48);
    check("t3_instr48", if_instr, 32'h01d3_1863);
    step();
    check("t3_pc4c_not_stale", if_pc, 32'h4C);
    check("t3_instr4c", if_instr, 32'h0000_1313);

    // Running past the end of the ROM.
    do_redirect(32'h78);
    step();
    check("t4_pc78", if_pc, 32'h78);
    check("t4_eor_78", 32'(end_of_rom), 32'h0);
    step();
    check("t4_pc7c", if_pc, 32'h7C);
    check("t4_eor_7c", 32'(end_of_rom), 32'h0);
    step();
    check("t4_pc80", if_pc, 32'h80);
    check("t4_instr80", if_instr, NOP);
    check("t4_eor_80", 32'(end_of_rom), 32'h1);
    step();
    check("t4_pc84", if_pc, 32'h84);
    do_redirect(32'h00);
    step();
    check("t4_back_pc0", if_pc, 32'h00);
    check("t4_eor_sticky", 32'(end_of_rom), 32'h1);

    // Misaligned redirect.
    do_redirect(32'h4A);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("t5_fault_set", 32'(fetch_fault), 32'h1);
    check("t5_fault_valid", 32'(if_valid), 32'h0);
    step();
    check("t5_fault_hold_valid", 32'(if_valid), 32'h0);
    check("t5_fault_hold", 32'(fetch_fault), 32'h1);
    do_redirect(32'h5C);
    check("t5_fault_clear", 32'(fetch_fault), 32'h0);
    check("t5_addr5c", rom_addr, 32'h5C);
`else
    check("t5_no_fault", 32'(fetch_fault), 32'h0);
    check("t5_aligned_addr", rom_addr, 32'h48);
    step();
    check("t5_pc48", if_pc, 32'h48);
    do_redirect(32'h5C);
`endif
    step();
    check("t5_pc5c", if_pc, 32'h5C);
    check("t5_instr5c", if_instr, 32'h0000_1713);

    // Drain with fetch disabled.
    if_ready = 1'b0;
    step();
    check("t6_head_held", if_pc, 32'h5C);
    fetch_en = 1'b0; if_ready = 1'b1;
    step();
    check("t6_drain_pc60", if_pc, 32'h60);
    check("t6_drain_busy", 32'(busy), 32'h1);
    step();
    check("t6_empty_valid", 32'(if_valid), 32'h0);
    check("t6_busy_fall", 32'(busy), 32'h0);
    check("t6_addr_held", rom_addr, 32'h64);

    // Asynchronous reset mid-stream.
    fetch_en = 1'b1;
    step(3);
    check("t6_stream_valid", 32'(if_valid), 32'h1);
    #3; rst_n = 1'b0; #1;
    check("t6_arst_valid", 32'(if_valid), 32'h0);
    check("t6_arst_addr", rom_addr, 32'h0);
    check("t6_arst_eor", 32'(end_of_rom), 32'h0);
    check("t6_arst_busy", 32'(busy), 32'h0);
    step();
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
